// File: rtl/uart_pkg.sv
// Shared types and constant helpers for the 8N1 UART byte receiver.
// The optional parity stage is enabled by defining UART_BYTE_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversampling tick, truncated toward zero.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // MID_SAMPLE: the sample index at the centre of a bit.
    function automatic int mid_sample(input int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks.
// A synchronous restart realigns the phase to the detected start edge.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF sync, 16x oversampling, 3-sample majority vote per bit.
// Define UART_BYTE_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int MID = mid_sample(OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);

    localparam logic [SCW-1:0] SC_EARLY = SCW'(MID - 1);
    localparam logic [SCW-1:0] SC_MID   = SCW'(MID);
    localparam logic [SCW-1:0] SC_LATE  = SCW'(MID + 1);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

    rx_state_t      state, state_nxt;
    logic           sync1, rxs;
    logic           tick, restart;
    logic [SCW-1:0] sc, sc_nxt;
    logic [2:0]     bc;
    logic [7:0]     shreg;
    logic           s_early, s_mid, vote;
    logic           hit_early, hit_mid, hit_late, wrap;
    logic           load_byte, err_pulse;
    logic           par_bad;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Decisions look at the sample index the current tick lands on.
    assign sc_nxt    = (sc == SC_LAST) ? '0 : sc + 1'b1;
    assign hit_early = tick && (sc_nxt == SC_EARLY);
    assign hit_mid   = tick && (sc_nxt == SC_MID);
    assign hit_late  = tick && (sc_nxt == SC_LATE);
    assign wrap      = tick && (sc_nxt == '0);
    assign vote      = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        load_byte = 1'b0;
        err_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    restart   = 1'b1;
                end
            end
            START: begin
                if (hit_late && vote) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (wrap && bc == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_BYTE_RX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_nxt = STOP;
                end
            end
`endif
            // A good stop bit returns to IDLE at once so back-to-back frames are caught.
            STOP: begin
                if (hit_late) begin
                    if (vote) begin
                        state_nxt = IDLE;
                        load_byte = !par_bad;
                        err_pulse = par_bad;
                    end else begin
                        state_nxt = BREAK;
                        err_pulse = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs && wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc        <= '0;
            bc        <= '0;
            shreg     <= '0;
            s_early   <= 1'b1;
            s_mid     <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= load_byte;
            frame_err <= err_pulse;
            if (load_byte) begin
                rx_data <= shreg;
            end
            // In BREAK, sc counts consecutive high ticks and restarts on any low sample.
            if (restart || (state != BREAK && state_nxt == BREAK) || (state == BREAK && !rxs)) begin
                sc <= '0;
            end else if (tick) begin
                sc <= sc_nxt;
            end
            if (hit_early) begin
                s_early <= rxs;
            end
            if (hit_mid) begin
                s_mid <= rxs;
            end
            if (state == START && wrap) begin
                bc <= '0;
            end else if (state == DATA && wrap) begin
                bc <= bc + 3'd1;
            end
            if (state == DATA && hit_late) begin
                shreg <= {vote, shreg[7:1]};
            end
        end
    end

`ifdef UART_BYTE_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if (restart) begin
            par_bad <= 1'b0;
        end else if (state == PARITY && hit_late) begin
            par_bad <= vote ^ (^shreg);
        end
    end
`else
    assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frames plus random bytes against a frame-level model.
// Honours UART_BYTE_RX_PARITY_EN for the even-parity variant.
module tb_uart_byte_rx;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 700_000;
    localparam int OVERSAMPLE = 16;
    localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT        = DIV * OVERSAMPLE;
`ifdef UART_BYTE_RX_PARITY_EN
    localparam int PRE       = 10;
    localparam bit PARITY_ON = 1'b1;
`else
    localparam int PRE       = 9;
    localparam bit PARITY_ON = 1'b0;
`endif

    typedef struct {
        bit         is_err;
        bit         busy_after;
        logic [7:0] data;
        int         t_lo;
        int         t_hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         cnt_valid = 0;
    int         cnt_err = 0;
    int         valid_times[$];
    exp_t       exp_q[$];
    exp_t       cmp_e;
    logic [7:0] model_data = 8'h00;
    logic [7:0] rnd_data;
    bit         rnd_stop;
    bit         rnd_flip;
    int         base_valid;
    int         base_err;
    int         exp_good;
    int         exp_bad;

    uart_byte_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual < lo || actual > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one frame bit-exact and, if asked, queues the event the spec says it must produce.
    // The stop bit is judged after its last mid-bit sample, so the strobe falls between
    // the centre and the third vote sample of the stop bit, plus sync and register delay.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_flip,
                                 input bit expect_evt);
        exp_t e;
        if (expect_evt) begin
            e.is_err     = !stop_bit || (PARITY_ON && par_flip);
            e.busy_after = !stop_bit;
            e.data       = data;
            e.t_lo       = cyc + PRE * BIT + 8 * DIV;
            e.t_hi       = cyc + PRE * BIT + 10 * DIV + 6;
            exp_q.push_back(e);
        end
        rxd = 1'b0;
        waitCycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitCycles(BIT);
        end
        if (PARITY_ON) begin
            rxd = (^data) ^ par_flip;
            waitCycles(BIT);
        end
        rxd = stop_bit;
        waitCycles(BIT);
    endtask

    // Every cycle: reset values, strobe legality against the model queue, and rx_data holding.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset rx_data", rx_data, 8'h00);
            checkOutput("reset rx_valid", rx_valid, 1'b0);
            checkOutput("reset frame_err", frame_err, 1'b0);
            checkOutput("reset busy", busy, 1'b0);
        end else begin
            if (rx_valid || frame_err) begin
                checkOutput("strobes exclusive", rx_valid & frame_err, 1'b0);
                if (rx_valid) begin
                    cnt_valid++;
                    valid_times.push_back(cyc);
                end
                if (frame_err) begin
                    cnt_err++;
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected strobe", {rx_valid, frame_err}, 2'b00);
                end else begin
                    cmp_e = exp_q.pop_front();
                    checkOutput("strobe kind frame_err", frame_err, cmp_e.is_err);
                    checkRange("strobe cycle", cyc, cmp_e.t_lo, cmp_e.t_hi);
                    checkOutput("busy at strobe", busy, cmp_e.busy_after);
                    if (rx_valid && !cmp_e.is_err) begin
                        model_data = cmp_e.data;
                    end
                end
            end
            checkOutput("rx_data", rx_data, model_data);
            if (exp_q.size() != 0 && cyc > exp_q[0].t_hi) begin
                checkRange("strobe overdue", cyc, exp_q[0].t_lo, exp_q[0].t_hi);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("[TB] FAIL watchdog: got %0d cycles, limit 150000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(4);
        rst = 1'b0;
        waitCycles(20);
        checkOutput("idle busy after reset", busy, 1'b0);

        // Single byte 'w'
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b1);
        waitCycles(2 * BIT);
        checkOutput("0x77 rx_data", rx_data, 8'h77);
        checkOutput("0x77 valid count", cnt_valid, 1);
        checkOutput("0x77 err count", cnt_err, 0);
        checkOutput("0x77 busy after", busy, 1'b0);

        // 'h' then 'H' with no idle gap
        applyStimulus(8'h68, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h48, 1'b1, 1'b0, 1'b1);
        waitCycles(2 * BIT);
        checkOutput("hH rx_data", rx_data, 8'h48);
        checkOutput("hH valid count", cnt_valid, 3);
        if (valid_times.size() >= 3) begin
            checkRange("hH strobe spacing", valid_times[2] - valid_times[1],
                       (PRE + 1) * BIT - DIV, (PRE + 1) * BIT + DIV);
        end

        // Short low glitch must be rejected by the start-bit vote
        rxd = 1'b0;
        waitCycles(5);
        checkOutput("glitch busy", busy, 1'b1);
        waitCycles(BIT * 3 / 8 - 5);
        rxd = 1'b1;
        waitCycles(9 * DIV + 8 - BIT * 3 / 8);
        checkOutput("glitch back to idle", busy, 1'b0);
        waitCycles(BIT);
        checkOutput("glitch valid count", cnt_valid, 3);
        checkOutput("glitch err count", cnt_err, 0);

        // Bad stop bit, line held low, then recovery with a good frame
        applyStimulus(8'h52, 1'b0, 1'b0, 1'b1);
        waitCycles(5 * BIT);
        checkOutput("break err count", cnt_err, 1);
        checkOutput("break busy while low", busy, 1'b1);
        rxd = 1'b1;
        waitCycles(2 * BIT);
        checkOutput("break rx_data kept", rx_data, 8'h48);
        checkOutput("break busy after", busy, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0, 1'b1);
        waitCycles(2 * BIT);
        checkOutput("0x72 rx_data", rx_data, 8'h72);
        checkOutput("0x72 valid count", cnt_valid, 4);
        checkOutput("0x72 err count", cnt_err, 1);

        // Reset in the middle of data bit 4, held until the line is idle
        fork
            applyStimulus(8'h31, 1'b1, 1'b0, 1'b0);
            begin
                waitCycles(5 * BIT + BIT / 2);
                rst = 1'b1;
                model_data = 8'h00;
                exp_q.delete();
            end
        join
        waitCycles(4);
        rst = 1'b0;
        waitCycles(BIT);
        checkOutput("post-reset rx_data", rx_data, 8'h00);
        checkOutput("post-reset valid count", cnt_valid, 4);
        applyStimulus(8'h37, 1'b1, 1'b0, 1'b1);
        waitCycles(2 * BIT);
        checkOutput("0x37 rx_data", rx_data, 8'h37);
        checkOutput("0x37 valid count", cnt_valid, 5);

`ifdef UART_BYTE_RX_PARITY_EN
        applyStimulus(8'h70, 1'b1, 1'b0, 1'b1);
        waitCycles(BIT);
        checkOutput("parity good rx_data", rx_data, 8'h70);
        checkOutput("parity good valid count", cnt_valid, 6);
        applyStimulus(8'h70, 1'b1, 1'b1, 1'b1);
        waitCycles(BIT);
        checkOutput("parity bad valid count", cnt_valid, 6);
        checkOutput("parity bad err count", cnt_err, 2);
        checkOutput("parity bad busy", busy, 1'b0);
`endif

        // Random bytes, random gaps (including none), occasional bad stop or parity
        base_valid = cnt_valid;
        base_err   = cnt_err;
        exp_good   = 0;
        exp_bad    = 0;
        for (int i = 0; i < 12; i++) begin
            rnd_data = 8'($urandom);
            rnd_stop = ($urandom_range(0, 4) != 0);
            rnd_flip = PARITY_ON && ($urandom_range(0, 4) == 0);
            applyStimulus(rnd_data, rnd_stop, rnd_flip, 1'b1);
            if (rnd_stop && !rnd_flip) begin
                exp_good++;
            end else begin
                exp_bad++;
            end
            if (!rnd_stop) begin
                rxd = 1'b1;
                waitCycles(2 * BIT);
            end
            waitCycles(int'($urandom_range(0, 2)) * BIT + int'($urandom_range(0, 20)));
        end
        waitCycles(2 * BIT);
        checkOutput("random valid count", cnt_valid - base_valid, exp_good);
        checkOutput("random err count", cnt_err - base_err, exp_bad);
        checkOutput("pending expectations", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
